spike_rate_decoder: RTL



---
 rtl/spike_rate_decoder_pkg.sv | 24 ++
 rtl/spike_rate_decoder_if.sv | 29 ++
 rtl/spike_rate_decoder_win_timer.sv | 59 +++++
 rtl/spike_rate_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_rate_decoder_pkg.sv
// spike_dec_pkg
// Shared types and defaults for the spike rate decoder.
//   state_t    : decoder FSM states (IDLE, COUNT)
//   CNT_W_DEF  : default spike-count / rate width
//   WIN_W_DEF  : default window-length width
//   sat_max()  : all-ones value for a given width, used as the count ceiling
// Optional feature macro used by the files that import this package:
//   SPIKE_DEC_LAT_EN (first-spike latency output).
package spike_dec_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 8;

  // Saturation ceiling of a w-bit counter.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if
// Valid/ready result channel between the rate decoder and its consumer.
//   rate_out   : spike count of the last completed window
//   rate_valid : rate_out holds an unconsumed result
//   rate_ready : consumer accepts rate_out when both valid and ready are high
//   first_lat  : index of the first spike in the window (SPIKE_DEC_LAT_EN only)
// Modports: master = decoder (producer), slave = consumer.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 8
`ifdef SPIKE_DEC_LAT_EN
  , parameter int WIN_W = 8
`endif
);

  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic             rate_ready;

`ifdef SPIKE_DEC_LAT_EN
  logic [WIN_W-1:0] first_lat;

  modport master (output rate_out, output rate_valid, output first_lat, input rate_ready);
  modport slave  (input rate_out, input rate_valid, input first_lat, output rate_ready);
`else
  modport master (output rate_out, output rate_valid, input rate_ready);
  modport slave  (input rate_out, input rate_valid, output rate_ready);
`endif

endinterface

// File: rtl/spike_rate_decoder_win_timer.sv
// spike_win_timer
// Window down-counter for the spike rate decoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a new window from win_len (0 means 2^WIN_W cycles)
//   stop       : abandon the current window
//   win_len    : requested window length, only looked at when start is high
//   last_cycle : registered strobe, high during the final cycle of a window
module spike_win_timer #(
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] win_len,
  output logic             last_cycle
);

  // One extra bit so a full 2^WIN_W window fits in the counter.
  logic [WIN_W:0] cnt_r;
  logic [WIN_W:0] cnt_nxt_s;
  logic [WIN_W:0] load_val_s;
  logic           last_r;

  // Map win_len=0 onto the longest window and choose the next count value.
  always_comb begin
    load_val_s = {1'b0, win_len};
    cnt_nxt_s  = cnt_r;
    if (win_len == {WIN_W{1'b0}}) begin
      load_val_s = {1'b1, {WIN_W{1'b0}}};
    end else begin
      load_val_s = {1'b0, win_len};
    end
    if (start) begin
      cnt_nxt_s = load_val_s;
    end else if (stop) begin
      cnt_nxt_s = {(WIN_W+1){1'b0}};
    end else if (cnt_r != {(WIN_W+1){1'b0}}) begin
      cnt_nxt_s = cnt_r - {{WIN_W{1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and last-cycle strobe registers; the strobe is precomputed from
  // the next count so it is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {(WIN_W+1){1'b0}};
      last_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      last_r <= (cnt_nxt_s == {{WIN_W{1'b0}}, 1'b1});
    end
  end

  assign last_cycle = last_r;

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Counts spike-high cycles over a programmable window and delivers each
// window's count on a valid/ready output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; windows run back-to-back while high
//   spike      : spike train, one count per high cycle
//   win_len    : window length in cycles (0 = 2^WIN_W), latched per window
//   busy       : high while counting a window
//   overrun    : sticky, a completed window was dropped (cleared on IDLE->COUNT)
//   rate_if    : result channel (rate_out / rate_valid / rate_ready)
// Optional macro SPIKE_DEC_LAT_EN adds rate_if.first_lat, the 0-based index
// of the first spike in the window (all-ones when there was none).
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 spike,
  input  logic [WIN_W-1:0]     win_len,
  output logic                 busy,
  output logic                 overrun,
  spike_rate_decoder_if.master rate_if
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_max(CNT_W));

  state_t           state_r;
  state_t           state_nxt_s;
  logic             start_s;
  logic             stop_s;
  logic             close_s;
  logic             ovr_clr_s;
  logic             last_cycle_s;

  logic [CNT_W-1:0] spike_cnt_r;
  logic [CNT_W-1:0] spike_inc_s;
  logic [CNT_W-1:0] win_sum_s;

  // Result pipeline stage: gives the one-cycle latency after the last sample.
  logic             res_pend_r;
  logic [CNT_W-1:0] res_r;

  logic [CNT_W-1:0] rate_out_r;
  logic             rate_valid_r;
  logic             overrun_r;

  spike_win_timer #(
    .WIN_W (WIN_W)
  ) u_win_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_s),
    .stop       (stop_s),
    .win_len    (win_len),
    .last_cycle (last_cycle_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and window control strobes.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    stop_s      = 1'b0;
    close_s     = 1'b0;
    ovr_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          start_s     = 1'b1;
          ovr_clr_s   = 1'b1;
          state_nxt_s = COUNT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COUNT: begin
        if (last_cycle_s) begin
          close_s = 1'b1;
          if (en) begin
            start_s     = 1'b1;
            state_nxt_s = COUNT;
          end else begin
            stop_s      = 1'b1;
            state_nxt_s = IDLE;
          end
        end else if (!en) begin
          // Partial window is discarded.
          stop_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = COUNT;
        end
      end
      default: begin
        stop_s      = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Saturating add of this cycle's spike sample to the running count.
  always_comb begin
    spike_inc_s = spike_cnt_r;
    win_sum_s   = spike_cnt_r;
    if (spike_cnt_r == CNT_SAT) begin
      spike_inc_s = spike_cnt_r;
    end else begin
      spike_inc_s = spike_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (spike) begin
      win_sum_s = spike_inc_s;
    end else begin
      win_sum_s = spike_cnt_r;
    end
  end

  // Running spike count; cleared at each window start or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt_r <= {CNT_W{1'b0}};
    end else if (start_s || stop_s) begin
      spike_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == COUNT) begin
      spike_cnt_r <= win_sum_s;
    end else begin
      spike_cnt_r <= spike_cnt_r;
    end
  end

  // Capture the finished window's count (including the last sample).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_pend_r <= 1'b0;
      res_r      <= {CNT_W{1'b0}};
    end else begin
      res_pend_r <= close_s;
      if (close_s) begin
        res_r <= win_sum_s;
      end else begin
        res_r <= res_r;
      end
    end
  end

  // A result may load when the register is empty or being drained this cycle.
  logic res_load_s;
  assign res_load_s = res_pend_r && (!rate_valid_r || rate_if.rate_ready);

  // Output register with valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out_r   <= {CNT_W{1'b0}};
      rate_valid_r <= 1'b0;
    end else if (res_load_s) begin
      rate_out_r   <= res_r;
      rate_valid_r <= 1'b1;
    end else if (rate_valid_r && rate_if.rate_ready) begin
      rate_out_r   <= rate_out_r;
      rate_valid_r <= 1'b0;
    end else begin
      rate_out_r   <= rate_out_r;
      rate_valid_r <= rate_valid_r;
    end
  end

  // Sticky overrun: a result dropped because the held one was not consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (res_pend_r && rate_valid_r && !rate_if.rate_ready) begin
      overrun_r <= 1'b1;
    end else if (ovr_clr_s) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

`ifdef SPIKE_DEC_LAT_EN
  logic [WIN_W-1:0] idx_r;
  logic             seen_r;
  logic [WIN_W-1:0] first_r;
  logic [WIN_W-1:0] win_first_s;
  logic [WIN_W-1:0] res_lat_r;
  logic [WIN_W-1:0] first_lat_r;

  // First-spike index including the current sample.
  always_comb begin
    win_first_s = first_r;
    if (!seen_r && spike) begin
      win_first_s = idx_r;
    end else begin
      win_first_s = first_r;
    end
  end

  // In-window sample index and first-spike tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= {WIN_W{1'b0}};
      seen_r  <= 1'b0;
      first_r <= {WIN_W{1'b1}};
    end else if (start_s || stop_s) begin
      idx_r   <= {WIN_W{1'b0}};
      seen_r  <= 1'b0;
      first_r <= {WIN_W{1'b1}};
    end else if (state_r == COUNT) begin
      idx_r   <= idx_r + {{(WIN_W-1){1'b0}}, 1'b1};
      seen_r  <= seen_r | spike;
      first_r <= win_first_s;
    end else begin
      idx_r   <= idx_r;
      seen_r  <= seen_r;
      first_r <= first_r;
    end
  end

  // Latency result stage and output register, same rules as rate_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_lat_r   <= {WIN_W{1'b1}};
      first_lat_r <= {WIN_W{1'b1}};
    end else begin
      if (close_s) begin
        res_lat_r <= win_first_s;
      end else begin
        res_lat_r <= res_lat_r;
      end
      if (res_load_s) begin
        first_lat_r <= res_lat_r;
      end else begin
        first_lat_r <= first_lat_r;
      end
    end
  end

  assign rate_if.first_lat = first_lat_r;
`endif

  assign rate_if.rate_out   = rate_out_r;
  assign rate_if.rate_valid = rate_valid_r;
  assign busy               = (state_r == COUNT);
  assign overrun            = overrun_r;

endmodule
